// File: rtl/multi_reg_load_sequencer_if.sv
// ---------------------------------------------------------------------------
// multi_reg_load_sequencer_if
// Bundles the decode-side command inputs, the data-memory read channel and
// the register-file write port of the multi-register load sequencer.
//   master : the sequencer (consumes command/read data, drives requests,
//            register-file writes and status)
//   slave  : the environment (decode, data memory, register file)
// ---------------------------------------------------------------------------
interface multi_reg_load_sequencer_if #(
    parameter int WORD       = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 16
);
    // decode command
    logic                  start_i;
    logic [NUM_REGS-1:0]   reg_list_i;
    logic [WORD-1:0]       base_addr_i;
    logic [ADDR_WIDTH-1:0] base_reg_i;
    logic                  writeback_base_i;
    // data memory read channel
    logic [WORD-1:0]       mem_rdata_i;
    logic                  mem_rvalid_i;
    logic                  mem_req_o;
    logic [WORD-1:0]       mem_addr_o;
    // register-file write port
    logic                  write_en_o;
    logic [ADDR_WIDTH-1:0] write_addr_o;
    logic [WORD-1:0]       reg_data_o;
    // pipeline status
    logic                  busy_o;
    logic                  stall_o;
    logic                  done_o;

    modport master (
        input  start_i, reg_list_i, base_addr_i, base_reg_i, writeback_base_i,
        input  mem_rdata_i, mem_rvalid_i,
        output mem_req_o, mem_addr_o,
        output write_en_o, write_addr_o, reg_data_o,
        output busy_o, stall_o, done_o
    );

    modport slave (
        output start_i, reg_list_i, base_addr_i, base_reg_i, writeback_base_i,
        output mem_rdata_i, mem_rvalid_i,
        input  mem_req_o, mem_addr_o,
        input  write_en_o, write_addr_o, reg_data_o,
        input  busy_o, stall_o, done_o
    );
endinterface

// File: rtl/multi_reg_load_sequencer.sv
// ---------------------------------------------------------------------------
// multi_reg_load_sequencer
// Executes Thumb multi-register loads (LDMIA/POP) through the register
// file's single write port. One word read is issued per listed register,
// lowest register first, with at most one read outstanding. Each returned
// word becomes one register-file write; an optional base writeback follows.
// The PC (highest register) is never written.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : command, memory read channel, register-file write port
//                  and busy/stall/done status (see interface file)
// All outputs are registered except stall_o, which must also cover the
// cycle in which start is presented.
// ---------------------------------------------------------------------------
module multi_reg_load_sequencer #(
    parameter int WORD       = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    multi_reg_load_sequencer_if.master   bus
);
    localparam int CNT_W  = $clog2(NUM_REGS + 1);
    localparam int PC_IDX = NUM_REGS - 1;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_WB_BASE, S_DONE
    } state_t;

    state_t                state_q;
    logic [NUM_REGS-1:0]   list_q;
    logic [WORD-1:0]       cur_addr_q;
    logic [WORD-1:0]       base_addr_q;
    logic [ADDR_WIDTH-1:0] base_reg_q;
    logic                  wb_q;
    logic                  base_in_list_q;
    logic [CNT_W-1:0]      count_q;
    logic [ADDR_WIDTH-1:0] cur_reg_q;

    logic                  mem_req_q;
    logic [WORD-1:0]       mem_addr_q;
    logic                  write_en_q;
    logic [ADDR_WIDTH-1:0] write_addr_q;
    logic [WORD-1:0]       reg_data_q;
    logic                  busy_q;
    logic                  done_q;

    // Incoming list with the PC bit dropped
    logic [NUM_REGS-1:0]   masked_list;
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_mask
            if (gi == PC_IDX) begin : g_pc
                assign masked_list[gi] = 1'b0;
            end else begin : g_gpr
                assign masked_list[gi] = bus.reg_list_i[gi];
            end
        end
    endgenerate

    logic [CNT_W-1:0]      start_count;
    logic [ADDR_WIDTH-1:0] low_idx;
    logic [NUM_REGS-1:0]   list_after;
    logic [WORD-1:0]       next_addr;

    always_comb begin
        start_count = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            start_count = start_count + CNT_W'(masked_list[i]);
        end
    end

    // Lowest set bit of the remaining list: scan downward so the last hit wins
    always_comb begin
        low_idx = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (list_q[i]) begin
                low_idx = ADDR_WIDTH'(i);
            end
        end
    end

    assign list_after = list_q & ~(NUM_REGS'(1) << cur_reg_q);
    assign next_addr  = cur_addr_q + WORD'(4);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            list_q         <= '0;
            cur_addr_q     <= '0;
            base_addr_q    <= '0;
            base_reg_q     <= '0;
            wb_q           <= 1'b0;
            base_in_list_q <= 1'b0;
            count_q        <= '0;
            cur_reg_q      <= '0;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            write_en_q     <= 1'b0;
            write_addr_q   <= '0;
            reg_data_q     <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            // Pulses default low; address/data hold their last values
            mem_req_q  <= 1'b0;
            write_en_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        list_q         <= masked_list;
                        cur_addr_q     <= bus.base_addr_i;
                        base_addr_q    <= bus.base_addr_i;
                        base_reg_q     <= bus.base_reg_i;
                        // A PC base would be a PC write; suppress it here
                        wb_q           <= bus.writeback_base_i &&
                                          (bus.base_reg_i != ADDR_WIDTH'(PC_IDX));
                        base_in_list_q <= masked_list[bus.base_reg_i];
                        count_q        <= start_count;
                        busy_q         <= 1'b1;
                        if (masked_list == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= S_REQ;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= bus.base_addr_i;
                        end
                    end
                end
                S_REQ: begin
                    cur_reg_q <= low_idx;
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.mem_rvalid_i) begin
                        write_en_q   <= 1'b1;
                        write_addr_q <= cur_reg_q;
                        reg_data_q   <= bus.mem_rdata_i;
                        list_q       <= list_after;
                        cur_addr_q   <= next_addr;
                        if (list_after != '0) begin
                            state_q    <= S_REQ;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= next_addr;
                        end else if (wb_q && !base_in_list_q) begin
                            state_q <= S_WB_BASE;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_WB_BASE: begin
                    write_en_q   <= 1'b1;
                    write_addr_q <= base_reg_q;
                    reg_data_q   <= base_addr_q + (WORD'(count_q) << 2);
                    state_q      <= S_DONE;
                    done_q       <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req_o    = mem_req_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.write_en_o   = write_en_q;
    assign bus.write_addr_o = write_addr_q;
    assign bus.reg_data_o   = reg_data_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
    // Stall in the very cycle start is presented, before busy is registered
    assign bus.stall_o      = busy_q | (bus.start_i & (state_q == S_IDLE));
endmodule

// File: tb/tb_multi_reg_load_sequencer.sv
module tb_multi_reg_load_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_reg_load_sequencer_if #(.WORD(32), .ADDR_WIDTH(4), .NUM_REGS(16)) bus ();

    multi_reg_load_sequencer #(.WORD(32), .ADDR_WIDTH(4), .NUM_REGS(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] d;
    } wr_t;

    logic [31:0] exp_req_q[$];
    wr_t         exp_wr_q[$];

    int tests_run  = 0;
    int fails      = 0;
    int wr_count   = 0;
    int resp_delay = 1;
    bit spur_req   = 1'b0;
    bit spur_idle  = 1'b0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_unexpected(input string name, input logic [95:0] act);
        tests_run++;
        fails++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a request or write
    logic [31:0] mon_addr;
    wr_t         mon_wr;
    initial begin
        forever begin
            @(negedge clk);
            if (bus.mem_req_o) begin
                if (exp_req_q.size() == 0) begin
                    fail_unexpected("unexpected_req", {64'd0, bus.mem_addr_o});
                end else begin
                    mon_addr = exp_req_q.pop_front();
                    check("req_addr", {64'd0, bus.mem_addr_o}, {64'd0, mon_addr});
                    $display("[TB] req  addr=%08h", bus.mem_addr_o);
                end
            end
            if (bus.write_en_o) begin
                wr_count++;
                if (exp_wr_q.size() == 0) begin
                    fail_unexpected("unexpected_write", {60'd0, bus.write_addr_o, bus.reg_data_o});
                end else begin
                    mon_wr = exp_wr_q.pop_front();
                    check("reg_write", {60'd0, bus.write_addr_o, bus.reg_data_o},
                          {60'd0, mon_wr.a, mon_wr.d});
                    $display("[TB] write R%0d=%08h", bus.write_addr_o, bus.reg_data_o);
                end
            end
        end
    end

    // Memory model: answers each request after resp_delay cycles with
    // {16'hDA7A, addr[15:0]}; optionally injects garbage rvalid pulses
    initial begin
        logic [31:0] pend;
        int          cd;
        cd = 0;
        pend = '0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_rvalid_i = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    bus.mem_rvalid_i = 1'b1;
                    bus.mem_rdata_i  = {16'hDA7A, pend[15:0]};
                end
            end else if (bus.mem_req_o) begin
                pend = bus.mem_addr_o;
                cd   = resp_delay;
                if (spur_req) begin
                    bus.mem_rvalid_i = 1'b1;
                    bus.mem_rdata_i  = 32'hDEADBEEF;
                end
            end else if (spur_idle) begin
                bus.mem_rvalid_i = 1'b1;
                bus.mem_rdata_i  = 32'hDEADBEEF;
            end
        end
    end

    task automatic start_seq(input logic [15:0] list, input logic [31:0] base,
                             input logic [3:0] breg, input logic wb);
        bus.reg_list_i       = list;
        bus.base_addr_i      = base;
        bus.base_reg_i       = breg;
        bus.writeback_base_i = wb;
        bus.start_i          = 1'b1;
        #1;
        check("stall_on_start", {95'd0, bus.stall_o}, 96'd1);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        bit held;
        n = 0;
        held = 1'b1;
        while (!bus.done_o && n < budget) begin
            if (!bus.busy_o || !bus.stall_o) held = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        check("done_seen", {95'd0, bus.done_o}, 96'd1);
        check("busy_stall_held", {95'd0, held}, 96'd1);
    endtask

    task automatic finish_test(input string name, input int w0, input int nwr);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check({name, "_busy_idle"}, {95'd0, bus.busy_o}, 96'd0);
        check({name, "_drained"}, 96'(exp_req_q.size() + exp_wr_q.size()), 96'd0);
        check({name, "_write_count"}, 96'(wr_count - w0), 96'(nwr));
    endtask

    int w0;
    int n;

    initial begin
        bus.start_i          = 1'b0;
        bus.reg_list_i       = '0;
        bus.base_addr_i      = '0;
        bus.base_reg_i       = '0;
        bus.writeback_base_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {91'd0, bus.mem_req_o, bus.write_en_o, bus.busy_o,
                             bus.done_o, bus.stall_o}, 96'd0);
        check("reset_data", {bus.mem_addr_o, bus.reg_data_o, 28'd0, bus.write_addr_o}, 96'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single register, latency check
        exp_req_q.push_back(32'h00000100);
        exp_wr_q.push_back('{a: 4'd2, d: 32'hDA7A0100});
        w0 = wr_count;
        start_seq(16'h0004, 32'h00000100, 4'd3, 1'b0);
        check("latency_req", {95'd0, bus.mem_req_o}, 96'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("latency_write", {95'd0, bus.write_en_o}, 96'd1);
        wait_done(50);
        finish_test("single", w0, 1);

        // Multiple registers with base writeback
        exp_req_q.push_back(32'h00000200);
        exp_req_q.push_back(32'h00000204);
        exp_req_q.push_back(32'h00000208);
        exp_req_q.push_back(32'h0000020C);
        exp_wr_q.push_back('{a: 4'd0, d: 32'hDA7A0200});
        exp_wr_q.push_back('{a: 4'd4, d: 32'hDA7A0204});
        exp_wr_q.push_back('{a: 4'd5, d: 32'hDA7A0208});
        exp_wr_q.push_back('{a: 4'd7, d: 32'hDA7A020C});
        exp_wr_q.push_back('{a: 4'd1, d: 32'h00000210});
        w0 = wr_count;
        start_seq(16'h00B1, 32'h00000200, 4'd1, 1'b1);
        wait_done(100);
        finish_test("multi_wb", w0, 5);

        // Base register in list: loaded value wins, no writeback
        exp_req_q.push_back(32'h00000600);
        exp_req_q.push_back(32'h00000604);
        exp_wr_q.push_back('{a: 4'd1, d: 32'hDA7A0600});
        exp_wr_q.push_back('{a: 4'd2, d: 32'hDA7A0604});
        w0 = wr_count;
        start_seq(16'h0006, 32'h00000600, 4'd1, 1'b1);
        wait_done(100);
        finish_test("base_in_list", w0, 2);

        // PC-only list: nothing issued, done one cycle after start
        w0 = wr_count;
        start_seq(16'h8000, 32'h00000700, 4'd2, 1'b1);
        check("empty_done", {94'd0, bus.done_o, bus.busy_o}, 96'd3);
        check("empty_no_req", {95'd0, bus.mem_req_o}, 96'd0);
        @(posedge clk);
        #1;
        check("empty_busy_one_cycle", {94'd0, bus.done_o, bus.busy_o}, 96'd0);
        finish_test("empty", w0, 0);

        // Address wrap with writeback
        exp_req_q.push_back(32'hFFFFFFF8);
        exp_req_q.push_back(32'hFFFFFFFC);
        exp_wr_q.push_back('{a: 4'd10, d: 32'hDA7AFFF8});
        exp_wr_q.push_back('{a: 4'd11, d: 32'hDA7AFFFC});
        exp_wr_q.push_back('{a: 4'd3,  d: 32'h00000000});
        w0 = wr_count;
        start_seq(16'h0C00, 32'hFFFFFFF8, 4'd3, 1'b1);
        wait_done(100);
        finish_test("wrap", w0, 3);

        // Slow memory with spurious rvalid in IDLE and REQ
        spur_idle = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        spur_idle  = 1'b0;
        resp_delay = 5;
        spur_req   = 1'b1;
        exp_req_q.push_back(32'h00000500);
        exp_req_q.push_back(32'h00000504);
        exp_wr_q.push_back('{a: 4'd0, d: 32'hDA7A0500});
        exp_wr_q.push_back('{a: 4'd1, d: 32'hDA7A0504});
        exp_wr_q.push_back('{a: 4'd2, d: 32'h00000508});
        w0 = wr_count;
        start_seq(16'h0003, 32'h00000500, 4'd2, 1'b1);
        wait_done(200);
        finish_test("delayed", w0, 3);
        resp_delay = 1;
        spur_req   = 1'b0;

        // Reset after the third write
        exp_req_q.push_back(32'h00000300);
        exp_req_q.push_back(32'h00000304);
        exp_req_q.push_back(32'h00000308);
        exp_req_q.push_back(32'h0000030C);
        exp_wr_q.push_back('{a: 4'd0, d: 32'hDA7A0300});
        exp_wr_q.push_back('{a: 4'd1, d: 32'hDA7A0304});
        exp_wr_q.push_back('{a: 4'd2, d: 32'hDA7A0308});
        w0 = wr_count;
        start_seq(16'h00FF, 32'h00000300, 4'd9, 1'b0);
        n = 0;
        while ((wr_count - w0) < 3 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("three_writes_before_reset", 96'(wr_count - w0), 96'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midreset_ctrl", {91'd0, bus.mem_req_o, bus.write_en_o, bus.busy_o,
                                bus.done_o, bus.stall_o}, 96'd0);
        check("midreset_data", {bus.mem_addr_o, bus.reg_data_o, 28'd0, bus.write_addr_o}, 96'd0);
        exp_req_q.delete();
        exp_wr_q.delete();
        spur_idle = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        spur_idle = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("no_write_after_reset", 96'(wr_count - w0), 96'd3);

        // Fresh sequence after reset
        exp_req_q.push_back(32'h00000400);
        exp_wr_q.push_back('{a: 4'd3, d: 32'hDA7A0400});
        exp_wr_q.push_back('{a: 4'd5, d: 32'h00000404});
        w0 = wr_count;
        start_seq(16'h0008, 32'h00000400, 4'd5, 1'b1);
        wait_done(100);
        finish_test("after_reset", w0, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end
endmodule

// File: doc/multi_reg_load_sequencer.md
Name: multi_reg_load_sequencer

Overview:
Write-side producer for the clocked register file's single write port. It executes Thumb multi-register loads (LDMIA/POP).
- Accepts a register list and base address from decode.
- Issues one word read per listed register, lowest register first.
- Drives one register-file write per returned word, then an optional base-register writeback.
- Holds the pipeline stalled until the sequence completes.

Parameters:
WORD, 32, data/address width (from GENERAL_DEFS)
ADDR_WIDTH, 4, register index width
NUM_REGS, 16, architectural register count; index 15 is the PC

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
start_i  input  1  begin sequence; sampled only in IDLE
reg_list_i  input  16  register mask; bit n set = load Rn
base_addr_i  input  WORD  start address (word aligned)
base_reg_i  input  ADDR_WIDTH  base register index
writeback_base_i  input  1  write final address to base register
mem_rdata_i  input  WORD  read data from data memory
mem_rvalid_i  input  1  mem_rdata_i valid this cycle
mem_req_o  output  1  read request, one-cycle pulse per word
mem_addr_o  output  WORD  read address, valid with mem_req_o
write_en_o  output  1  register-file write enable
write_addr_o  output  ADDR_WIDTH  register-file write index
reg_data_o  output  WORD  register-file write data
busy_o  output  1  sequence in progress
stall_o  output  1  freeze fetch/decode
done_o  output  1  one-cycle completion pulse

Behaviour:
- Reset (synchronous, rst_i=1 at clock edge): state=IDLE; all outputs 0; latched list/address/count cleared. Reset mid-sequence aborts immediately; no further writes or requests.
- Masking: bit 15 of reg_list_i is forced to 0 on latch. The PC is never written by this block.
- Latched count = popcount(masked list), 5 bits.
- All outputs are registered except stall_o. stall_o = busy_o OR (start_i AND state==IDLE).
- busy_o is 1 in every state except IDLE.

State machine:
- IDLE: on start_i, latch masked list, cur_addr=base_addr_i, base, writeback flag, and base_in_list = list[base_reg_i].
  - Masked list empty -> DONE.
  - Otherwise -> REQ.
  - start_i in any other state is ignored.
- REQ: mem_req_o=1 and mem_addr_o=cur_addr for exactly this cycle; cur_reg = index of lowest set bit. Next state is WAIT.
- WAIT: hold until mem_rvalid_i=1 (unbounded wait allowed). On that cycle, register for the next cycle:
  - write_en_o=1, write_addr_o=cur_reg, reg_data_o=mem_rdata_i.
  - Clear bit cur_reg; cur_addr += 4 (wrap modulo 2^WORD).
  - Remaining list nonempty -> REQ.
  - Else if writeback flag AND NOT base_in_list -> WB_BASE.
  - Else -> DONE.
- WB_BASE: next cycle write_en_o=1, write_addr_o=base, reg_data_o = base_addr + 4*count. Next state is DONE.
- DONE: done_o=1 for one cycle. Next state is IDLE.
- mem_rvalid_i outside WAIT is ignored.
- write_en_o is high for exactly one cycle per write; write_addr_o/reg_data_o hold their last values when write_en_o=0.
- Base register in list: the loaded value wins and no base writeback occurs, even if writeback_base_i=1.
- Latency: start accepted at cycle T -> mem_req_o at T+1. With rvalid at T+2, write_en_o rises at T+3.
- Next request: issued one cycle after each write is registered, so at most one read is outstanding.

Test Plan:
- Single reg: start, list=0x0004, base=0x100, no writeback; rvalid=1 the cycle after each request -> mem_req_o addr 0x100; then write R2=rdata; done_o pulse; exactly 1 write.
- Multi with writeback: list=0x00B1 (R0,R4,R5,R7), base_reg=1, base=0x200, writeback=1 -> addresses 0x200/204/208/20C; writes R0,R4,R5,R7 in order; then R1=0x210; done_o.
- Base in list: list=0x0006, base_reg=1, writeback=1 -> R1,R2 loaded from memory; no 0x... base write; 2 writes total.
- Empty/PC-only list: reg_list_i=0x8000, writeback=1 -> no mem_req_o, no write_en_o; done_o one cycle after start; busy_o high exactly 1 cycle.
- Delayed memory: rvalid asserted 5 cycles after each request, plus spurious rvalid during REQ/IDLE -> busy/stall held throughout; spurious rvalid produces no write.
- Reset mid-op: list=0x00FF, assert rst_i after the 3rd write -> next cycle all outputs 0, IDLE; later rvalid causes no write; new start runs normally.
